// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS     = 8;
    localparam int FRAME_SYMBOLS = 10;
    localparam int BIT_IDX_W     = $clog2(DATA_BITS);

    function automatic int cycles_per_symbol(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Width clamps to 1 so a rejected CPS still yields a legal vector before the fatal check fires.
    function automatic int symbol_counter_width(input int cps);
        return (cps < 2) ? 1 : $clog2(cps);
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the memory-mapped IO block (master) and the UART transmitter (slave).
interface uart_transmitter_if;

    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );

endinterface

// File: rtl/uart_symbol_counter.sv
// Free-running 0..CPS-1 symbol timer with synchronous clear and a one-cycle wrap pulse.
module uart_symbol_counter
    import uart_pkg::*;
#(
    parameter int CPS   = 16,
    parameter int WIDTH = symbol_counter_width(CPS)
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_wrap
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(CPS - 1);

    generate
        if (CPS < 2) begin : g_cps_check
            $fatal(1, "uart_symbol_counter: cycles per symbol must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;

    // Wrap is suppressed while cleared so an idle owner never sees a stray pulse.
    assign o_wrap = !i_clear && (r_count == LAST_COUNT);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear || o_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter: one byte per ready/valid handshake, LSB first, registered line output.
//
// state    | meaning
// ST_IDLE  | line high, ready asserted, waiting for a valid byte
// ST_START | start bit (line low) for one symbol
// ST_DATA  | eight data bits from shift[0], shifting right each symbol
// ST_STOP  | stop bit (line high) for one symbol, then back to idle
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    uart_transmitter_if.slave   s_if,
    output logic                o_sout
);

    localparam int CPS = cycles_per_symbol(ClockFreq, BaudRate);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e            r_state;
    uart_state_e            w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [BIT_IDX_W-1:0]   w_bit_idx_next;
    logic                   r_sout;
    logic                   w_sout_next;
    logic                   w_idle;
    logic                   w_accept;
    logic                   w_wrap;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && s_if.data_in_valid;

    // Held in clear while idle, so every frame starts its first symbol from count 0.
    uart_symbol_counter #(
        .CPS (CPS)
    ) u_symbol_counter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_idle),
        .o_wrap    (w_wrap)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_sout    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_sout    <= w_sout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_sout_next    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next   = ST_START;
                    w_shift_next   = s_if.data_in;
                    w_bit_idx_next = '0;
                end
            end
            ST_START: begin
                if (w_wrap) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (w_wrap) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_wrap) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // The line level is decoded from the upcoming state so the register lands on the symbol boundary.
        case (w_state_next)
            ST_IDLE:  w_sout_next = 1'b1;
            ST_START: w_sout_next = 1'b0;
            ST_DATA:  w_sout_next = w_shift_next[0];
            ST_STOP:  w_sout_next = 1'b1;
            default:  w_sout_next = 1'b1;
        endcase
    end

    assign s_if.data_in_ready = w_idle;
    assign o_sout             = r_sout;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboarded bench for uart_transmitter at CPS = 16: stimulus queues expected bytes, a serial monitor decodes and compares.
module tb_uart_transmitter;

    logic clk = 1'b0;
    logic rst_n;
    logic sout;

    uart_transmitter_if u_if ();

    uart_transmitter #(
        .ClockFreq (16),
        .BaudRate  (1)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .s_if      (u_if),
        .o_sout    (sout)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Serial monitor: samples each symbol at its midpoint and retires one scoreboard entry per frame.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       st;
        logic       sp;
        bit         ab;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !sout) begin
                start_q.push_back(cyc);
                ab = 1'b0;
                mon_wait(8, ab);
                st = sout;
                for (int i = 0; i < 8; i++) begin
                    if (!ab) mon_wait(16, ab);
                    b[i] = sout;
                end
                if (!ab) mon_wait(16, ab);
                sp = sout;
                if (ab) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    prev = sout;
                end else begin
                    frames_seen++;
                    if (exp_q.size() == 0) check("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
                    else check("frame_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    check("frame_start_stop", {30'h0, st, sp}, 32'h1);
                    prev = sp;
                end
            end else begin
                prev = sout;
            end
        end
    end

    task automatic send(input logic [7:0] b, output int e0);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!u_if.data_in_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_ready_wait", {31'h0, u_if.data_in_ready}, 32'h1);
        u_if.data_in       = b;
        u_if.data_in_valid = 1'b1;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        e0 = cyc;
        u_if.data_in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_seen < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait", frames_seen, target);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!u_if.data_in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'h0, u_if.data_in_ready}, 32'h1);
    endtask

    initial begin
        int   e0;
        int   e0b;
        int   n;
        int   f0;
        int   s0;
        int   trans;
        int   highs;
        logic prev;

        // Reset with a pending byte: nothing may start.
        rst_n              = 1'b0;
        u_if.data_in_valid = 1'b1;
        u_if.data_in       = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("reset_sout", {31'h0, sout}, 32'h1);
            check("reset_ready", {31'h0, u_if.data_in_ready}, 32'h1);
        end
        @(posedge clk);
        #1;
        rst_n              = 1'b1;
        u_if.data_in_valid = 1'b0;
        trans = 0;
        highs = 0;
        prev  = sout;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i < 20 && sout === 1'b1) highs++;
            if (sout !== prev) trans++;
            prev = sout;
        end
        check("idle_high_20", highs, 20);
        check("idle_no_toggle_50", trans, 0);
        check("idle_no_frame", frames_seen, 0);

        // Single byte 0xA5.
        f0 = frames_seen;
        s0 = start_q.size();
        send(8'hA5, e0);
        n = 0;
        @(negedge clk);
        while (!u_if.data_in_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", n, 160);
        check("ready_return_cycle", cyc - e0, 160);
        wait_frames(f0 + 1);
        if (start_q.size() > s0) check("start_latency", start_q[s0], e0);
        else check("start_seen", start_q.size(), s0 + 1);
        repeat (30) @(negedge clk);
        check("single_frame_count", frames_seen, f0 + 1);

        // Back-to-back 0x00 then 0xFF with valid held.
        f0 = frames_seen;
        s0 = start_q.size();
        wait_ready();
        @(posedge clk);
        #1;
        u_if.data_in       = 8'h00;
        u_if.data_in_valid = 1'b1;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1;
        e0 = cyc;
        u_if.data_in = 8'hFF;
        exp_q.push_back(8'hFF);
        n = 0;
        @(negedge clk);
        while (!u_if.data_in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        u_if.data_in_valid = 1'b0;
        e0b = cyc;
        check("b2b_accept_gap", e0b - e0, 161);
        wait_frames(f0 + 2);
        if (start_q.size() > s0 + 1) check("b2b_start_gap", start_q[s0+1] - start_q[s0], 161);
        else check("b2b_starts_seen", start_q.size(), s0 + 2);

        // Data stability: later DataIn and a stray valid during DATA are ignored.
        wait_ready();
        f0 = frames_seen;
        send(8'h3C, e0);
        repeat (40) @(posedge clk);
        #1;
        u_if.data_in       = 8'hC3;
        u_if.data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.data_in_valid = 1'b0;
        check("stray_valid_ignored_ready", {31'h0, u_if.data_in_ready}, 32'h0);
        wait_frames(f0 + 1);
        wait_ready();
        repeat (30) @(negedge clk);
        check("stability_frame_count", frames_seen, f0 + 1);

        // Reset at E0+70 aborts the frame; the next byte goes out cleanly.
        f0 = frames_seen;
        send(8'h55, e0);
        repeat (69) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_sout", {31'h0, sout}, 32'h1);
        check("abort_ready", {31'h0, u_if.data_in_ready}, 32'h1);
        check("abort_cycle", cyc - e0, 70);
        repeat (200) @(negedge clk);
        check("abort_no_frame", frames_seen, f0);
        check("abort_queue_drained", exp_q.size(), 0);
        send(8'h81, e0);
        wait_frames(f0 + 1);

        // Single-cycle valid after a long idle gives exactly one frame.
        wait_ready();
        f0 = frames_seen;
        send(8'h6E, e0);
        wait_frames(f0 + 1);
        wait_ready();
        repeat (40) @(negedge clk);
        check("one_pulse_one_frame", frames_seen, f0 + 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got time limit expiry, required bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial 8N1 transmitter that turns one byte per ready/valid handshake into a start bit, eight data bits (LSB first) and a stop bit on the FPGA serial output. It sits directly downstream of the memory-mapped IO interface: the IO interface drives the byte and valid strobe on a store to the UART transmit address and polls ready through the status address. Together with the receiver it forms the UART block.

## Interface
- ClockFreq, 50_000_000, system clock frequency in Hz
- BaudRate, 115_200, serial line rate in baud
- Clock  input  1  system clock; all state updates on posedge
- Reset  input  1  synchronous, active-low reset; sampled on posedge Clock
- DataIn  input  8  byte to transmit; sampled only on the accepting edge
- DataInValid  input  1  producer has a byte on DataIn
- DataInReady  output  1  transmitter idle, can accept a byte
- SOut  output  1  serial line; idle and stop level is 1

## Operation
- CyclesPerSymbol (CPS) = ClockFreq / BaudRate, truncating integer divide. CPS must be at least 2; elaboration fails otherwise.
- The symbol counter is $clog2(CPS) bits wide and counts 0..CPS-1, then wraps to 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - DataInReady = 1, SOut = 1.
  - On an edge with DataInValid = 1 (accept), latch DataIn into the shift register, clear the counter and bit index, and go to START.
- START:
  - SOut = 0 for CPS cycles.
  - On counter wrap, go to DATA with bit index 0.
- DATA:
  - SOut = shift[0].
  - On each counter wrap, shift right and increment the 3-bit bit index.
  - After the wrap with index 7, go to STOP.
- STOP:
  - SOut = 1 for CPS cycles.
  - On counter wrap, go to IDLE.
- DataInReady is decoded only from state == IDLE; there is no combinational path from DataInValid.
- SOut is driven from a register, so it is glitch-free.
- Outside IDLE, DataInValid and DataIn are ignored. The producer must hold valid until it sees ready.
- Changes on DataIn after the accepting edge have no effect on the frame in flight.
- Reset values when Reset = 0 is sampled: state IDLE, SOut = 1, DataInReady = 1, counter 0, bit index 0, shift register 0.
- Reset mid-frame aborts the frame. SOut is 1 from the edge that samples reset, and no partial byte is resumed.

## Timing
- Accept edge E0. SOut is valid from E0 onward as follows:
  - Start bit: [E0, E0+CPS).
  - Data bit i: [E0+(1+i)·CPS, E0+(2+i)·CPS).
  - Stop bit: [E0+9·CPS, E0+10·CPS).
- DataInReady is 0 from E0 to E0+10·CPS, then 1 again.
- The earliest next accept edge is E0+10·CPS+1 cycle. A back-to-back frame period is therefore 10·CPS+1 cycles, with exactly one idle cycle at SOut = 1 between the stop bit and the next start bit.
- DataInValid = 1 held continuously with a new byte produces a frame every 10·CPS+1 cycles.
- Reset asserted on the same edge as DataInValid: reset wins and the byte is not accepted.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, 2-bit encoding);
  - the constants DATA_BITS = 8 and FRAME_SYMBOLS = 10;
  - the function computing CPS and the counter width.
- One natural sub-module, uart_symbol_counter: a parameterised 0..CPS-1 counter with clear input and wrap pulse output. The receiver reuses it.
- The top level holds the FSM, the shift register and the bit index.

## Test plan
Bench parameters ClockFreq = 16, BaudRate = 1, so CPS = 16.

- **Reset:** hold Reset = 0 for 3 cycles with DataInValid = 1 and DataIn = 0xFF -> SOut = 1 and DataInReady = 1 throughout, and SOut stays 1 for 20 cycles after release with valid low.
- **Single byte:** send 0xA5 -> sampling SOut mid-symbol gives 0,1,0,1,0,0,1,0,1,1. DataInReady is 0 for exactly 160 cycles and returns to 1 at E0+160.
- **Back-to-back:** hold valid for 0x00 then 0xFF -> the second start bit falling edge lands exactly 161 cycles after the first. The frames decode as 0,0×8,1 and 0,1×8,1, with one idle cycle at SOut = 1 between them.
- **Data stability:** accept 0x3C, then drive DataIn = 0xC3 and pulse valid during DATA -> the decoded byte is 0x3C, and no extra frame starts until ready is high.
- **Reset mid-frame:** accept 0x55 and assert Reset at E0+70 for 1 cycle -> SOut = 1 from the next edge and DataInReady = 1. A following accept of 0x81 produces a clean full frame.
- **Ready protocol:** keep valid low for 50 cycles after reset -> no transition on SOut. Assert valid for one cycle -> exactly one frame is produced.
